// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : bounce_generator
// Purpose  : Emulates a mechanical push-button. A command requests a new
//            target level; the output jumps to it at once, then bounces
//            pseudo-randomly (LFSR driven, minimum hold per level) for a
//            fixed window before being forced back to the target.
// Ports    : clk         - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            cmd_valid   - request for a new target level
//            cmd_level   - requested level, sampled on acceptance
//            glitch_en   - 1 enables bounce toggles, 0 gives clean edges
//            cmd_ready   - command can be accepted (IDLE)
//            glitchy_out - emulated button level (registered)
//            busy        - bounce window in progress
//            done        - one-cycle pulse once the output has settled
// Revision : 1.0 - initial release
// ============================================================================
module bounce_generator #(
  parameter int unsigned bounce_cycles = 40,       // 1..65535
  parameter int unsigned min_hold      = 4,        // 1..255
  parameter logic [15:0] lfsr_seed     = 16'hACE1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_level,
  input  logic glitch_en,
  output logic cmd_ready,
  output logic glitchy_out,
  output logic busy,
  output logic done
);

  // An all-zero Galois LFSR would lock up, so a zero seed is promoted.
  localparam logic [15:0] seed_eff  = (lfsr_seed == 16'h0000) ? 16'h0001 : lfsr_seed;
  localparam logic [15:0] lfsr_mask = 16'hB400;
  localparam logic [15:0] win_last  = 16'(bounce_cycles - 1);
  localparam logic [7:0]  hold_min  = 8'(min_hold - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    BOUNCE = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        target_q, target_d;
  logic        out_q, out_d;
  logic        done_q, done_d;
  logic [15:0] win_q, win_d;
  logic [7:0]  hold_q, hold_d;
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    out_d    = out_q;
    done_d   = 1'b0;
    win_d    = win_q;
    hold_d   = hold_q;

    // Free-running: advances in every state.
    lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ lfsr_mask) : (lfsr_q >> 1);

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_level != out_q) begin
            target_d = cmd_level;
            out_d    = cmd_level;
            state_d  = BOUNCE;
            win_d    = 16'd0;
            hold_d   = 8'd0;
          end else begin
            // Already at the requested level: acknowledge without a window.
            done_d = 1'b1;
          end
        end
      end
      BOUNCE: begin
        if (win_q == win_last) begin
          // Final forced segment ignores min_hold.
          out_d   = target_q;
          state_d = IDLE;
          done_d  = 1'b1;
          win_d   = 16'd0;
          hold_d  = 8'd0;
        end else begin
          win_d = win_q + 16'd1;
          // Saturate so long windows cannot wrap the hold counter.
          hold_d = (hold_q != 8'hFF) ? (hold_q + 8'd1) : hold_q;
          if (glitch_en && (hold_q >= hold_min) && lfsr_q[0]) begin
            out_d  = ~out_q;
            hold_d = 8'd0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      out_q    <= 1'b0;
      done_q   <= 1'b0;
      win_q    <= 16'd0;
      hold_q   <= 8'd0;
      lfsr_q   <= seed_eff;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      out_q    <= out_d;
      done_q   <= done_d;
      win_q    <= win_d;
      hold_q   <= hold_d;
      lfsr_q   <= lfsr_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign busy        = (state_q == BOUNCE);
  assign glitchy_out = out_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_bounce_generator
// Purpose  : Scoreboard bench for bounce_generator. A reference model fed by
//            the same inputs predicts every output each cycle and queues the
//            expected settle level/cycle per accepted command; a monitor pops
//            that queue on each done pulse. A behavioural debouncer watches
//            the output for the loopback scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

  localparam int BC = 40;
  localparam int MH = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_level = 1'b0;
  logic glitch_en = 1'b1;
  logic cmd_ready, glitchy_out, busy, done;

  int checks = 0;
  int errors = 0;

  bounce_generator #(
    .bounce_cycles(BC),
    .min_hold(MH),
    .lfsr_seed(SEED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_level(cmd_level),
    .glitch_en(glitch_en),
    .cmd_ready(cmd_ready),
    .glitchy_out(glitchy_out),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard producer ----------------
  typedef struct {
    bit lvl;
    int due;
  } exp_t;
  exp_t sb[$];

  bit          m_busy = 1'b0, m_out = 1'b0, m_target = 1'b0, m_done = 1'b0;
  int          m_left = 0, m_since = 0, m_cyc = 0;
  logic [15:0] m_lfsr = SEED;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_busy = 0; m_out = 0; m_target = 0; m_done = 0;
        m_left = 0; m_since = 0; m_lfsr = SEED;
        sb.delete();
      end else begin
        m_cyc++;
        m_done = 0;
        if (!m_busy) begin
          if (cmd_valid) begin
            if (cmd_level != m_out) begin
              m_busy = 1; m_target = cmd_level; m_out = cmd_level;
              m_left = BC; m_since = 0;
              sb.push_back('{lvl: cmd_level, due: m_cyc + BC});
            end else begin
              m_done = 1;
              sb.push_back('{lvl: cmd_level, due: m_cyc});
            end
          end
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_out = m_target; m_busy = 0; m_done = 1;
          end else begin
            m_since++;
            if (glitch_en && m_since >= MH && m_lfsr[0]) begin
              m_out = !m_out;
              m_since = 0;
            end
          end
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
    end
  end

  // ---------------- monitor / scoreboard consumer ----------------
  int   n_trans = 0;
  int   seg_len = 0;
  logic prev_out = 1'b0, prev_busy = 1'b0;
  // behavioural debouncer: sample every 10 cycles, 5 equal samples to switch
  int   deb_tick = 0, deb_cnt = 0;
  logic deb_last = 1'b0, deb_out = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("glitchy_out", glitchy_out, m_out);
      chk("busy", busy, m_busy);
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("done", done, m_done);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", m_cyc, e.due);
          chk("done_level", glitchy_out, e.lvl);
        end
      end
      if (glitchy_out !== prev_out) begin
        n_trans++;
        if (busy && prev_busy) chk("min_hold_segment", seg_len >= MH, 1);
        seg_len = 1;
      end else begin
        seg_len++;
      end
      prev_out  = glitchy_out;
      prev_busy = busy;

      deb_tick++;
      if (deb_tick == 10) begin
        deb_tick = 0;
        if (glitchy_out == deb_last) deb_cnt++;
        else deb_cnt = 1;
        deb_last = glitchy_out;
        if (deb_cnt >= 5) deb_out = deb_last;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic lvl);
    cmd_valid = 1'b1;
    cmd_level = lvl;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t0;
    repeat (3) tick();
    chk("rst_glitchy_out", glitchy_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // Press with bounce enabled.
    send(1'b1);
    chk("press_level_at_accept", glitchy_out, 1);
    repeat (45) tick();
    chk("press_settled", glitchy_out, 1);

    // Release, then press with ignored commands at window cycles 5 and 39.
    send(1'b0);
    repeat (45) tick();
    send(1'b1);
    repeat (4) tick();
    send(1'b0);
    repeat (33) tick();
    send(1'b0);
    repeat (6) tick();
    chk("ignore_target_kept", glitchy_out, 1);

    // Same-level command.
    send(1'b0);
    repeat (45) tick();
    t0 = n_trans;
    send(1'b0);
    repeat (5) tick();
    chk("same_level_no_transition", n_trans - t0, 0);

    // Reset at cycle 20 of a window, then accept on the first edge after.
    send(1'b1);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_glitchy_out", glitchy_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cmd_ready", cmd_ready, 1);
    chk("midrst_done", done, 0);
    tick();
    rst_n = 1'b1;
    send(1'b1);
    chk("post_rst_accept_busy", busy, 1);
    repeat (45) tick();

    // Clean edges; second command held valid so it lands on the done cycle.
    glitch_en = 1'b0;
    send(1'b0);
    repeat (45) tick();
    t0 = n_trans;
    cmd_valid = 1'b1;
    cmd_level = 1'b1;
    tick();
    cmd_level = 1'b0;
    repeat (40) tick();
    chk("clean_press_transitions", n_trans - t0, 1);
    tick();
    cmd_valid = 1'b0;
    repeat (45) tick();
    chk("clean_total_transitions", n_trans - t0, 2);

    // Loopback into the debouncer.
    glitch_en = 1'b1;
    send(1'b1);
    repeat (99) tick();
    chk("debounced_high", deb_out, 1);
    send(1'b0);
    repeat (100) tick();
    chk("debounced_low", deb_out, 0);

    repeat (5) tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter bounce_cycles, default 40: bounce window length in clk cycles; legal range 1..65535.
REQ-002 Parameter min_hold, default 4: minimum cycles any level is held before a bounce toggle; legal range 1..255.
REQ-003 Parameter lfsr_seed, default 16'hACE1: LFSR reset value; a seed of 0 SHALL be replaced by 16'h0001.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  request for a new target level.
REQ-007 cmd_level  input  1  target level; sampled only on an accepted command.
REQ-008 glitch_en  input  1  1 = bounce toggles enabled; 0 = clean edges only; sampled every cycle.
REQ-009 cmd_ready  output  1  high when a command can be accepted.
REQ-010 glitchy_out  output  1  emulated bouncing button level; registered.
REQ-011 busy  output  1  high while a bounce window is in progress.
REQ-012 done  output  1  one-cycle pulse when glitchy_out has settled at the target.

Function
REQ-013 The block SHALL have two states, IDLE and BOUNCE; cmd_ready SHALL be combinational (state==IDLE); busy SHALL be (state==BOUNCE).
REQ-014 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_valid while busy SHALL be ignored, with no effect and no queueing.
REQ-015 On acceptance with cmd_level != glitchy_out: the target SHALL be latched, glitchy_out SHALL equal the target from the accepting edge, the state SHALL become BOUNCE, and the window and hold counters SHALL clear to 0.
REQ-016 On acceptance with cmd_level == glitchy_out: the state SHALL stay IDLE, glitchy_out SHALL be unchanged, and done SHALL pulse for the one cycle after the accepting edge.
REQ-017 A 16-bit Galois LFSR (mask 16'hB400, shift right) SHALL advance every cycle in every state.
REQ-018 In BOUNCE, each edge SHALL increment the window counter and the hold counter; if glitch_en=1, hold counter >= min_hold-1 and lfsr[0]=1, then glitchy_out SHALL toggle and the hold counter SHALL clear.
REQ-019 When the window counter equals bounce_cycles-1, the next edge SHALL force glitchy_out to the target, return the state to IDLE, and assert done for exactly one cycle.
REQ-020 done SHALL therefore rise exactly bounce_cycles edges after the accepting edge; a command on the cycle done is high SHALL be accepted.
REQ-021 The final forced segment SHALL be exempt from min_hold; every other segment within the window SHALL be held at least min_hold cycles.
REQ-022 With glitch_en=0 for the whole window, glitchy_out SHALL make exactly one transition, at acceptance.
REQ-023 Counters SHALL be 16 bits (window) and 8 bits (hold) and SHALL never wrap within legal parameter ranges.

Reset
REQ-024 While rst_n=0, outputs SHALL be immediately: glitchy_out=0, busy=0, done=0, cmd_ready=1; state=IDLE, counters=0, LFSR=seed.
REQ-025 Reset asserted mid-window SHALL abort the window with no done pulse; the first edge after deassertion SHALL be able to accept a command.

Verification
REQ-026 Reset: assert rst_n=0 at cycle 20 of a window -> glitchy_out=0, busy=0, cmd_ready=1 before the next clk edge; no done pulse.
REQ-027 Press: defaults, cmd_level=1, glitch_en=1 -> glitchy_out=1 at accept; done exactly 40 cycles later; glitchy_out=1 thereafter; every non-final segment >= 4 cycles; toggle sequence matches a reference LFSR model.
REQ-028 Busy ignore: second command (level 0) at cycles 5 and 39 of a window -> not accepted; target stays 1; done at cycle 40 only.
REQ-029 Same level: glitchy_out=0, command level 0 -> busy never rises; done high for the single cycle after accept; no transitions.
REQ-030 Clean: glitch_en=0, press then release with bounce_cycles=40 -> exactly one transition per command; done at 40 and 80+ cycles.
REQ-031 Loopback into debouncer (sample_count_max=10, pulse_count_max=5, bounce_cycles=40): press held 100 cycles -> debounced output high before release; release -> debounced output falls.
